// File: rtl/rr_burst_arbiter.sv
// Purpose : round-robin burst arbiter; it pops four input FIFOs and steers each popped word to one of four output FIFOs.
// Latency : pop is combinational in the grant cycle; push/mux_sel/demux_sel are registered and follow one cycle later.
// Backpress: an input is skipped while the almost-full flag of its head destination is set; pops never stall a push.
//
// Ports:
//   clk, reset              single clock, synchronous active-high reset
//   empty0..3, dest0..3     input-FIFO empty flags and head-word destinations
//   afull0..3               output-FIFO almost-full flags
//   pop0..3                 combinational pop strobes (at most one high)
//   push0..3                registered push strobes to output FIFOs
//   mux_sel, demux_sel      registered source / destination of the word on the data path
//   idle                    high while the FSM is in IDLE
module rr_burst_arbiter #(
  parameter int unsigned BURST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       empty0,
  input  logic       empty1,
  input  logic       empty2,
  input  logic       empty3,
  input  logic [1:0] dest0,
  input  logic [1:0] dest1,
  input  logic [1:0] dest2,
  input  logic [1:0] dest3,
  input  logic       afull0,
  input  logic       afull1,
  input  logic       afull2,
  input  logic       afull3,
  output logic       pop0,
  output logic       pop1,
  output logic       pop2,
  output logic       pop3,
  output logic       push0,
  output logic       push1,
  output logic       push2,
  output logic       push3,
  output logic [1:0] mux_sel,
  output logic [1:0] demux_sel,
  output logic       idle
);

  localparam logic [3:0] BURST_C = 4'(BURST);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_g, w_g_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [3:0] r_push;
  logic [1:0] r_mux_sel;
  logic [1:0] r_demux_sel;

  logic [3:0] w_empty;
  logic [3:0] w_afull;
  logic [1:0] w_dest [4];
  logic [3:0] w_elig;
  logic       w_stay;
  logic       w_found;
  logic [1:0] w_win;
  logic [1:0] w_idx;
  logic [3:0] w_pop;
  logic       w_pop_any;

  assign w_empty   = {empty3, empty2, empty1, empty0};
  assign w_afull   = {afull3, afull2, afull1, afull0};
  assign w_dest[0] = dest0;
  assign w_dest[1] = dest1;
  assign w_dest[2] = dest2;
  assign w_dest[3] = dest3;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_elig[i] = !w_empty[i] && !w_afull[w_dest[i]];
    end
  end

  // Continue the current burst only while it is live and under budget.
  assign w_stay = (r_state == SERVE) && w_elig[r_g] && (r_cnt < BURST_C);

  // Rotating search g+1, g+2, g+3, g. Reaching g here (burst exhausted and
  // nobody else eligible) counts as a fresh grant, so the burst restarts at 1.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_g;
    w_idx   = r_g;
    if (w_stay) begin
      w_found = 1'b1;
      w_win   = r_g;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        w_idx = r_g + 2'(k);
        if (!w_found && w_elig[w_idx]) begin
          w_found = 1'b1;
          w_win   = w_idx;
        end
      end
    end
  end

  assign w_pop_any = w_found && !reset;
  assign w_pop     = w_pop_any ? (4'b0001 << w_win) : 4'b0000;

  // Next-state / grant-update process.
  always_comb begin
    w_state_nxt = IDLE;
    w_g_nxt     = r_g;
    w_cnt_nxt   = r_cnt;
    if (w_found) begin
      w_state_nxt = SERVE;
      if (w_stay) begin
        w_cnt_nxt = r_cnt + 4'd1;
      end else begin
        w_g_nxt   = w_win;
        w_cnt_nxt = 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_g     <= 2'd3;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_g     <= w_g_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Data-path steering registers, aligned with the word the FIFO returns
  // one cycle after the pop. Selects hold across cycles without a pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_push      <= 4'b0000;
      r_mux_sel   <= 2'd0;
      r_demux_sel <= 2'd0;
    end else if (w_pop_any) begin
      r_push      <= 4'b0001 << w_dest[w_win];
      r_mux_sel   <= w_win;
      r_demux_sel <= w_dest[w_win];
    end else begin
      r_push      <= 4'b0000;
    end
  end

  assign {pop3, pop2, pop1, pop0}     = w_pop;
  assign {push3, push2, push1, push0} = r_push;
  assign mux_sel   = r_mux_sel;
  assign demux_sel = r_demux_sel;
  assign idle      = (r_state == IDLE);

endmodule

// File: tb/tb_rr_burst_arbiter.sv
module tb_rr_burst_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] emp;
  logic [3:0] af;
  logic [7:0] dst;
  logic       pop0, pop1, pop2, pop3;
  logic       push0, push1, push2, push3;
  logic [1:0] mux_sel, demux_sel;
  logic       idle;

  int errors = 0;
  int checks = 0;

  rr_burst_arbiter #(.BURST(4)) dut (
    .clk(clk), .reset(reset),
    .empty0(emp[0]), .empty1(emp[1]), .empty2(emp[2]), .empty3(emp[3]),
    .dest0(dst[1:0]), .dest1(dst[3:2]), .dest2(dst[5:4]), .dest3(dst[7:6]),
    .afull0(af[0]), .afull1(af[1]), .afull2(af[2]), .afull3(af[3]),
    .pop0(pop0), .pop1(pop1), .pop2(pop2), .pop3(pop3),
    .push0(push0), .push1(push1), .push2(push2), .push3(push3),
    .mux_sel(mux_sel), .demux_sel(demux_sel), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] emp;
    logic [3:0] af;
    logic [7:0] dst;
    logic [3:0] pop;
    logic [3:0] push;
    logic [1:0] mux;
    logic [1:0] dmx;
    logic       idle;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] e, input logic [3:0] a,
                     input logic [7:0] d, input logic [3:0] p, input logic [3:0] q,
                     input logic [1:0] m, input logic [1:0] x, input logic i);
    vec_t v;
    v.rst = r; v.emp = e; v.af = a; v.dst = d;
    v.pop = p; v.push = q; v.mux = m; v.dmx = x; v.idle = i;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got pop=%b push=%b mux=%0d dmx=%0d idle=%b, required pop=%b push=%b mux=%0d dmx=%0d idle=%b",
               name, got[12:9], got[8:5], got[4:3], got[2:1], got[0],
               exp[12:9], exp[8:5], exp[4:3], exp[2:1], exp[0]);
    end
  endtask

  function automatic logic [12:0] outs();
    return {pop3, pop2, pop1, pop0, push3, push2, push1, push0, mux_sel, demux_sel, idle};
  endfunction

  initial begin
    // Reset state: all inputs eligible, yet pops are forced low.
    add(1, 4'b0000, 4'b0000, 8'hAA, 4'b0000, 4'b0000, 0, 0, 1);
    // All empty for 10 cycles, assorted dests.
    for (int i = 0; i < 10; i++)
      add(0, 4'b1111, 4'b0000, 8'(i * 37 + 5), 4'b0000, 4'b0000, 0, 0, 1);
    // All non-empty, all dest 2: bursts of 4 rotating 0,1,2,3,0.
    for (int k = 1; k <= 17; k++)
      add(0, 4'b0000, 4'b0000, 8'hAA, 4'b0001 << (((k - 1) / 4) % 4),
          (k == 1) ? 4'b0000 : 4'b0100, (k == 1) ? 2'd0 : 2'(((k - 2) / 4) % 4),
          (k == 1) ? 2'd0 : 2'd2, (k == 1));
    // Only input 2 (dest 1): back-to-back pops across burst boundaries.
    for (int k = 1; k <= 12; k++)
      add(0, 4'b1011, 4'b0000, 8'h10, 4'b0100,
          (k == 1) ? 4'b0100 : 4'b0010, (k == 1) ? 2'd0 : 2'd2,
          (k == 1) ? 2'd2 : 2'd1, 0);
    // Input 0 blocked by afull1, input 1 served; then afull1 drops.
    for (int k = 1; k <= 10; k++)
      add(0, 4'b1100, (k <= 6) ? 4'b0010 : 4'b0000, 8'h0D,
          (k <= 8) ? 4'b0010 : 4'b0001,
          (k == 1 || k == 10) ? 4'b0010 : 4'b1000,
          (k == 1) ? 2'd2 : (k == 10) ? 2'd0 : 2'd1,
          (k == 1 || k == 10) ? 2'd1 : 2'd3, 0);
    // Go idle; selects hold, pushes drop.
    add(0, 4'b1111, 4'b0000, 8'h0E, 4'b0000, 4'b0010, 0, 1, 0);
    add(0, 4'b1111, 4'b0000, 8'h0E, 4'b0000, 4'b0000, 0, 1, 1);
    // Input 0 popped twice, then empty0 rises: switch to input 1 same cycle.
    add(0, 4'b1110, 4'b0000, 8'h0E, 4'b0001, 4'b0000, 0, 1, 1);
    add(0, 4'b1100, 4'b0000, 8'h0E, 4'b0001, 4'b0100, 0, 2, 0);
    add(0, 4'b1101, 4'b0000, 8'h0E, 4'b0010, 4'b0100, 0, 2, 0);
    add(0, 4'b1101, 4'b0000, 8'h0E, 4'b0010, 4'b1000, 1, 3, 0);
    // Input 3 mid-burst (cnt=2), then a 1-cycle reset.
    add(0, 4'b0111, 4'b0000, 8'h0E, 4'b1000, 4'b1000, 1, 3, 0);
    add(0, 4'b0111, 4'b0000, 8'h0E, 4'b1000, 4'b0001, 3, 0, 0);
    add(1, 4'b0111, 4'b0000, 8'h0E, 4'b0000, 4'b0001, 3, 0, 0);
    add(0, 4'b0110, 4'b0000, 8'h0E, 4'b0001, 4'b0000, 0, 0, 1);
    add(0, 4'b0110, 4'b0000, 8'h0E, 4'b0001, 4'b0100, 0, 2, 0);
    // afull2 rises in the push cycle: push stays, input 0 now blocked.
    add(0, 4'b0110, 4'b0100, 8'h0E, 4'b1000, 4'b0100, 0, 2, 0);
    add(0, 4'b1111, 4'b0000, 8'h0E, 4'b0000, 4'b0001, 3, 0, 0);
    add(0, 4'b1111, 4'b0000, 8'h0E, 4'b0000, 4'b0000, 3, 0, 1);
    add(0, 4'b1100, 4'b0000, 8'h0E, 4'b0001, 4'b0000, 3, 0, 1);

    reset = 1'b1; emp = 4'b1111; af = 4'b0000; dst = 8'h00;
    repeat (2) @(posedge clk);

    for (int n = 0; n < vecs.size(); n++) begin
      @(negedge clk);
      reset = vecs[n].rst; emp = vecs[n].emp; af = vecs[n].af; dst = vecs[n].dst;
      #1;
      check($sformatf("row%0d", n), outs(),
            {vecs[n].pop, vecs[n].push, vecs[n].mux, vecs[n].dmx, vecs[n].idle});
    end

    // Hand-written: reset held two cycles with a push pending, then release.
    @(negedge clk);
    reset = 1'b1; emp = 4'b0000; af = 4'b0000; dst = 8'h0E;
    #1 check("rst_pending_push", outs(), {4'b0000, 4'b0100, 2'd0, 2'd2, 1'b0});
    @(negedge clk); #1;
    check("rst_second_cycle", outs(), {4'b0000, 4'b0000, 2'd0, 2'd0, 1'b1});
    @(negedge clk);
    reset = 1'b0;
    #1 check("first_grant_input0", outs(), {4'b0001, 4'b0000, 2'd0, 2'd0, 1'b1});
    @(negedge clk); #1;
    check("after_release", outs(), {4'b0001, 4'b0100, 2'd0, 2'd2, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_burst_arbiter.md
RR_BURST_ARBITER -- requirements
Module: rr_burst_arbiter

Interface
- REQ-001: Parameter BURST, default 4 (legal range 1..15): maximum consecutive pops granted to one input FIFO before rotation.
- REQ-002: clk  input  1  single clock; all state updates on its rising edge.
- REQ-003: reset  input  1  synchronous, active-high reset.
- REQ-004: empty0..empty3  input  1 each  input-FIFO empty flags.
- REQ-005: dest0..dest3  input  2 each  destination output FIFO carried in the head word of input FIFO i.
- REQ-006: afull0..afull3  input  1 each  output-FIFO almost-full flags.
- REQ-007: pop0..pop3  output  1 each  combinational pop strobe to input FIFO i.
- REQ-008: push0..push3  output  1 each  registered push strobe to output FIFO j.
- REQ-009: mux_sel  output  2  registered index of the input whose popped word is on the data path this cycle.
- REQ-010: demux_sel  output  2  registered destination index aligned with the push strobes.
- REQ-011: idle  output  1  high when the state is IDLE.

Function
- REQ-012: eligible[i] SHALL be (!empty_i && !afull[dest_i]), evaluated every cycle.
- REQ-013: The block SHALL keep a grant register g (2 bits), a burst counter cnt (4 bits) and a two-state FSM {IDLE, SERVE}.
- REQ-014: Winner selection: if state==SERVE, eligible[g] and cnt<BURST, winner=g; otherwise winner=first eligible input in order g+1, g+2, g+3, g (mod 4).
- REQ-015: If a winner exists, pop_winner SHALL be 1 in the same cycle, and all other pops SHALL be 0.
- REQ-016: At most one pop SHALL be high in any cycle.
- REQ-017: No eligible input SHALL mean all pops 0; next state IDLE; g and cnt hold.
- REQ-018: Winner==g while in SERVE SHALL give cnt<=cnt+1. Any other winner SHALL give g<=winner and cnt<=1. In both cases next state SERVE.
- REQ-019: When cnt reaches BURST and g is the only eligible input, g SHALL be re-granted with cnt<=1 and no idle cycle.
- REQ-020: One cycle after a pop of input w with dest d, push_d SHALL be 1, demux_sel SHALL equal d and mux_sel SHALL equal w (1-cycle FIFO read latency).
- REQ-021: In a cycle following a cycle with no pop, all pushes SHALL be 0 and mux_sel/demux_sel SHALL hold their values.
- REQ-022: A pop SHALL never be issued to an input whose head destination has afull=1. The afull seen in the pop cycle is authoritative; afull rising in the push cycle SHALL NOT cancel that push.
- REQ-023: An input losing eligibility mid-burst SHALL cause a switch to the next eligible input in the same cycle, with no bubble.
- REQ-024: While the FSM is in IDLE, the search SHALL start at g+1, so fairness is preserved across idle periods.

Reset
- REQ-025: While reset==1, all pops SHALL be forced to 0 combinationally.
- REQ-026: On a rising edge with reset==1: g<=3, cnt<=0, state<=IDLE, push0..3<=0, mux_sel<=0, demux_sel<=0. idle SHALL then read 1.
- REQ-027: Reset asserted mid-burst SHALL abort the burst. A push already pending from the prior cycle's pop SHALL still appear in the cycle reset is first sampled high; pushes SHALL be 0 from the cycle after that.
- REQ-028: After reset release, the first grant SHALL go to the lowest-numbered eligible input, starting at input 0.

Verification
- REQ-029: empty=4'b1111, afull=4'b0000, random dests, 10 cycles -> pops=0, pushes=0, idle=1 throughout.
- REQ-030: empty=4'b0000, afull=0, all dests=2, BURST=4 -> pop0 x4, pop1 x4, pop2 x4, pop3 x4, then repeat. push2 SHALL be high every cycle from 1 cycle after the first pop. mux_sel SHALL follow 0,0,0,0,1,... with 1-cycle lag.
- REQ-031: Only input 2 non-empty (dest2=1) for 12 cycles -> pop2 high every cycle with no gap at burst boundaries. push1 SHALL be high 1 cycle later each cycle.
- REQ-032: dest0=1 with afull1=1, dest1=3 with afull3=0, inputs 0 and 1 non-empty -> pop0 never high and input 1 served. Then drop afull1 -> input 0 served once input 1's burst of 4 ends.
- REQ-033: Inputs 0 and 1 non-empty, and empty0 rises after the second pop0 -> pop1 SHALL be high in that same cycle with no idle cycle. The pushes SHALL match the popped dests.
- REQ-034: Reset pulsed for 1 cycle while input 3 is mid-burst (cnt=2) -> pop3=0 during reset. The pending push appears once, then the pushes are 0. After release, input 0 wins first if eligible.
